route_compute_xy: RTL and testbench
===================================

Name: route_compute_xy

Overview:
- Dimension-ordered (XY) route computation unit for one router of a 2-D mesh NoC with virtual-channel routers.
- Given the current router ID and a packet's destination router ID, produces the output direction for the next hop, or flags local ejection.
- Output is registered: one pipeline stage, single clock domain, sits in the router's route-compute (RC) stage ahead of VC allocation.

Parameters:
- NUM_ROUTERS, 16, total routers in the mesh; IDs 0..NUM_ROUTERS-1, row-major.
- ROUTER_PER_ROW, 4, routers per mesh row (number of columns).
- ROUTER_ID_BITS, $clog2(NUM_ROUTERS), derived width of router IDs; localparam, not overridable.

Ports:
- clk, input, 1, rising-edge clock.
- reset_n, input, 1, asynchronous active-low reset.
- valid_in, input, 1, request valid; inputs sampled on a clk rising edge when high.
- current_router, input, ROUTER_ID_BITS, ID of this router.
- dest_router, input, ROUTER_ID_BITS, destination router ID of the head flit.
- valid_out, output, 1, registered result valid.
- direction, output, 2, next-hop direction: 00 North, 01 South, 10 East, 11 West.
- eject, output, 1, destination reached; route to local port. direction=00 when eject=1.
- id_error, output, 1, current_router or dest_router is >= NUM_ROUTERS.

Behaviour:
- Coordinates: row = id / ROUTER_PER_ROW, col = id % ROUTER_PER_ROW. Row 0 is the north edge; row increases southward. Col 0 is the west edge; col increases eastward.
- XY routing, X first. Rules are evaluated in this priority order:
  - dest col > cur col -> East (10).
  - dest col < cur col -> West (11).
  - Columns equal and dest row > cur row -> South (01).
  - Columns equal and dest row < cur row -> North (00).
  - Both equal -> eject=1, direction=00.
- id_error=1 when either ID is >= NUM_ROUTERS. In that case direction=00 and eject=0. This can only occur when NUM_ROUTERS is not a power of two.
- Latency: exactly 1 cycle.
  - A request sampled at edge N with valid_in=1 appears on direction/eject/id_error with valid_out=1 after edge N.
  - valid_in=0 at an edge -> valid_out=0 after that edge.
  - direction/eject/id_error hold their previous values while valid_out=0.
- Fully pipelined: accepts a new request every cycle with no back-pressure and no internal state beyond the output registers.
- Reset: reset_n low asynchronously forces valid_out=0, direction=00, eject=0, id_error=0 immediately, independent of clk.
  - Outputs stay at these values while reset_n is low.
  - Release is sampled at the next rising edge.
  - A request in flight during reset is discarded.
- Division and modulo use the parameters. The implementation handles non-power-of-two ROUTER_PER_ROW (e.g. 3).
- Column and row compares are unsigned.
- No wrap-around: the mesh is not a torus.

Test Plan:
- Reset: assert reset_n=0 mid-stream with valid_in=1 -> outputs go 0 asynchronously, before the next edge. First edge after release with valid_in=0 -> valid_out=0.
- Four directions, 4x4 mesh, current_router=5 (row 1, col 1), one request per cycle back-to-back, each response one cycle later:
  - dest 7 -> 10
  - dest 4 -> 11
  - dest 13 -> 01
  - dest 1 -> 00
- X-first priority: current=0, dest=15 -> East (10). current=15, dest=0 -> West (11). current=12, dest=0 -> North (00).
- Local: current=9, dest=9 -> eject=1, direction=00, valid_out=1.
- Idle: valid_in=0 for one cycle between requests -> valid_out=0 that cycle, data outputs hold.
- Non-power-of-two: NUM_ROUTERS=9, ROUTER_PER_ROW=3.
  - current=4, dest=2 -> East (10).
  - current=4, dest=12 -> id_error=1.
  - Random regression of 1000 pairs checked against the XY rules.

Source files
------------

// File: rtl/route_compute_xy.sv
// rtl/route_compute_xy.sv - registered XY dimension-ordered route computation for a 2-D mesh router
module route_compute_xy #(
  parameter int NUM_ROUTERS    = 16,
  parameter int ROUTER_PER_ROW = 4,
  localparam int ROUTER_ID_BITS = $clog2(NUM_ROUTERS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      valid_in,
  input  logic [ROUTER_ID_BITS-1:0] current_router,
  input  logic [ROUTER_ID_BITS-1:0] dest_router,
  output logic                      valid_out,
  output logic [1:0]                direction,
  output logic                      eject,
  output logic                      id_error
);

  localparam logic [1:0] DIR_NORTH = 2'b00;
  localparam logic [1:0] DIR_SOUTH = 2'b01;
  localparam logic [1:0] DIR_EAST  = 2'b10;
  localparam logic [1:0] DIR_WEST  = 2'b11;

  localparam int unsigned NR_U  = NUM_ROUTERS;
  localparam int unsigned RPR_U = ROUTER_PER_ROW;

  // Work in 32-bit unsigned so non-power-of-two row widths divide cleanly.
  int unsigned cur_id, dst_id;
  int unsigned cur_row, cur_col, dst_row, dst_col;

  assign cur_id  = 32'(current_router);
  assign dst_id  = 32'(dest_router);
  assign cur_row = cur_id / RPR_U;
  assign cur_col = cur_id % RPR_U;
  assign dst_row = dst_id / RPR_U;
  assign dst_col = dst_id % RPR_U;

  logic [1:0] dir_c;
  logic       eject_c;
  logic       err_c;

  // X is resolved fully before Y, which keeps the routing deadlock-free.
  always_comb begin
    dir_c   = DIR_NORTH;
    eject_c = 1'b0;
    err_c   = 1'b0;
    if (cur_id >= NR_U || dst_id >= NR_U) begin
      err_c = 1'b1;
    end else if (dst_col > cur_col) begin
      dir_c = DIR_EAST;
    end else if (dst_col < cur_col) begin
      dir_c = DIR_WEST;
    end else if (dst_row > cur_row) begin
      dir_c = DIR_SOUTH;
    end else if (dst_row < cur_row) begin
      dir_c = DIR_NORTH;
    end else begin
      eject_c = 1'b1;
    end
  end

  // Data registers only load on a valid request so they hold across idle cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_out <= 1'b0;
      direction <= DIR_NORTH;
      eject     <= 1'b0;
      id_error  <= 1'b0;
    end else begin
      valid_out <= valid_in;
      if (valid_in) begin
        direction <= dir_c;
        eject     <= eject_c;
        id_error  <= err_c;
      end
    end
  end

endmodule

// File: tb/tb_route_compute_xy.sv
// tb/tb_route_compute_xy.sv - self-checking bench for route_compute_xy on a 4x4 and a 3x3 mesh
module tb_route_compute_xy;

  typedef struct {
    logic [3:0] cur;
    logic [3:0] dest;
    logic [1:0] dir;
    logic       ej;
    logic       err;
  } vec_t;

  logic       clk;
  logic       reset_n;
  logic       v4_in, v3_in;
  logic [3:0] cur4, dst4, cur3, dst3;
  logic       v4_out, ej4, err4;
  logic       v3_out, ej3, err3;
  logic [1:0] dir4, dir3;

  int n_cmp  = 0;
  int n_fail = 0;

  route_compute_xy #(.NUM_ROUTERS(16), .ROUTER_PER_ROW(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .valid_in(v4_in),
    .current_router(cur4), .dest_router(dst4),
    .valid_out(v4_out), .direction(dir4), .eject(ej4), .id_error(err4)
  );

  route_compute_xy #(.NUM_ROUTERS(9), .ROUTER_PER_ROW(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .valid_in(v3_in),
    .current_router(cur3), .dest_router(dst3),
    .valid_out(v3_out), .direction(dir3), .eject(ej3), .id_error(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference XY rules for the 3x3 random regression: {valid, err, eject, dir}
  function automatic logic [4:0] xy_ref(input int c, input int d);
    int cr, cc, dr, dc;
    cr = c / 3; cc = c % 3; dr = d / 3; dc = d % 3;
    if (c >= 9 || d >= 9) return 5'b1_1_0_00;
    if (dc > cc)          return 5'b1_0_0_10;
    if (dc < cc)          return 5'b1_0_0_11;
    if (dr > cr)          return 5'b1_0_0_01;
    if (dr < cr)          return 5'b1_0_0_00;
    return 5'b1_0_1_00;
  endfunction

  vec_t t4[11];
  vec_t t3[9];

  initial begin
    t4[0]  = '{4'd5,  4'd7,  2'b10, 1'b0, 1'b0};
    t4[1]  = '{4'd5,  4'd4,  2'b11, 1'b0, 1'b0};
    t4[2]  = '{4'd5,  4'd13, 2'b01, 1'b0, 1'b0};
    t4[3]  = '{4'd5,  4'd1,  2'b00, 1'b0, 1'b0};
    t4[4]  = '{4'd0,  4'd15, 2'b10, 1'b0, 1'b0};
    t4[5]  = '{4'd15, 4'd0,  2'b11, 1'b0, 1'b0};
    t4[6]  = '{4'd12, 4'd0,  2'b00, 1'b0, 1'b0};
    t4[7]  = '{4'd9,  4'd9,  2'b00, 1'b1, 1'b0};
    t4[8]  = '{4'd3,  4'd12, 2'b11, 1'b0, 1'b0};
    t4[9]  = '{4'd12, 4'd3,  2'b10, 1'b0, 1'b0};
    t4[10] = '{4'd10, 4'd2,  2'b00, 1'b0, 1'b0};

    t3[0] = '{4'd4,  4'd2,  2'b10, 1'b0, 1'b0};
    t3[1] = '{4'd4,  4'd12, 2'b00, 1'b0, 1'b1};
    t3[2] = '{4'd12, 4'd4,  2'b00, 1'b0, 1'b1};
    t3[3] = '{4'd0,  4'd8,  2'b10, 1'b0, 1'b0};
    t3[4] = '{4'd8,  4'd6,  2'b11, 1'b0, 1'b0};
    t3[5] = '{4'd1,  4'd7,  2'b01, 1'b0, 1'b0};
    t3[6] = '{4'd7,  4'd1,  2'b00, 1'b0, 1'b0};
    t3[7] = '{4'd4,  4'd4,  2'b00, 1'b1, 1'b0};
    t3[8] = '{4'd8,  4'd9,  2'b00, 1'b0, 1'b1};

    reset_n = 1'b0;
    v4_in = 1'b0; cur4 = '0; dst4 = '0;
    v3_in = 1'b0; cur3 = '0; dst3 = '0;
    #1;
    check("reset4", {v4_out, err4, ej4, dir4}, 8'h00);
    check("reset3", {v3_out, err3, ej3, dir3}, 8'h00);

    @(posedge clk); #1;
    reset_n = 1'b1;

    // 4x4 table, one request per cycle back-to-back
    for (int i = 0; i < 11; i++) begin
      v4_in = 1'b1; cur4 = t4[i].cur; dst4 = t4[i].dest;
      @(posedge clk); #1;
      check($sformatf("mesh4_vec%0d", i), {v4_out, err4, ej4, dir4},
            {3'b000, 1'b1, t4[i].err, t4[i].ej, t4[i].dir});
    end
    v4_in = 1'b0;

    // 3x3 table
    for (int i = 0; i < 9; i++) begin
      v3_in = 1'b1; cur3 = t3[i].cur; dst3 = t3[i].dest;
      @(posedge clk); #1;
      check($sformatf("mesh3_vec%0d", i), {v3_out, err3, ej3, dir3},
            {3'b000, 1'b1, t3[i].err, t3[i].ej, t3[i].dir});
    end
    v3_in = 1'b0;

    // Idle cycle between requests: valid drops, data holds
    v4_in = 1'b1; cur4 = 4'd5; dst4 = 4'd13;
    @(posedge clk); #1;
    check("idle_pre", {v4_out, err4, ej4, dir4}, 8'h11);
    v4_in = 1'b0; cur4 = 4'd5; dst4 = 4'd4;
    @(posedge clk); #1;
    check("idle_gap", {v4_out, err4, ej4, dir4}, 8'h01);
    v4_in = 1'b1;
    @(posedge clk); #1;
    check("idle_post", {v4_out, err4, ej4, dir4}, 8'h13);

    // Asynchronous reset mid-stream with a request in flight
    cur4 = 4'd5; dst4 = 4'd7;
    @(posedge clk); #1;
    check("pre_reset", {v4_out, err4, ej4, dir4}, 8'h12);
    cur4 = 4'd9; dst4 = 4'd9;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", {v4_out, err4, ej4, dir4}, 8'h00);
    @(posedge clk); #1;
    check("reset_hold", {v4_out, err4, ej4, dir4}, 8'h00);
    v4_in = 1'b0;
    #2;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("release_idle", {v4_out, err4, ej4, dir4}, 8'h00);

    // Random regression on the 3x3 mesh, IDs spanning the full 4-bit range
    for (int i = 0; i < 1000; i++) begin
      int c, d;
      c = $urandom_range(0, 15);
      d = $urandom_range(0, 15);
      v3_in = 1'b1; cur3 = 4'(c); dst3 = 4'(d);
      @(posedge clk); #1;
      check($sformatf("rand_%0d_%0d", c, d), {v3_out, err3, ej3, dir3}, {3'b000, xy_ref(c, d)});
    end
    v3_in = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
